step_editor: RTL and testbench

- Consumer end of the button-matrix event interface: takes the debounced `button_index`/`button_pressed` pair from the matrix scanner and turns each qualified press into an edit of the 16-step pattern.
- Holds the pattern as `beats` (16 steps x 3 bits) and runs a tempo-driven playhead over it.
- Sits between the button matrix controller and the sequencer model/LED/audio logic in `top`.

---
 rtl/step_editor_pkg.sv | 33 +++
 rtl/step_editor_if.sv | 29 ++
 rtl/step_editor_tempo_counter.sv | 57 +++++
 rtl/step_editor.sv | 187 ++++++++++++++++++
 tb/tb_step_editor.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/step_editor_pkg.sv
// sequencer_pkg: shared constants, types and step-slice helpers for the step editor.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package sequencer_pkg;

  localparam int STEPS  = 16;
  localparam int VAL_W  = 3;
  localparam int IDX_W  = $clog2(STEPS);
  localparam int PAT_W  = STEPS * VAL_W;
  localparam int BASE_W = $clog2(PAT_W);

  typedef logic [VAL_W-1:0]  step_val_t;
  typedef logic [PAT_W-1:0]  pattern_t;
  typedef logic [IDX_W-1:0]  step_idx_t;
  typedef logic [BASE_W-1:0] bit_pos_t;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    HELD
  } press_state_t;

  // Bit position of the low bit of a step inside the packed pattern.
  function automatic bit_pos_t step_base(step_idx_t idx);
    return bit_pos_t'(idx) * bit_pos_t'(VAL_W);
  endfunction

  // Value stored at one step of the pattern.
  function automatic step_val_t get_step(pattern_t pat, step_idx_t idx);
    return pat[step_base(idx) +: VAL_W];
  endfunction

endpackage

// File: rtl/step_editor_if.sv
// step_editor_if: button-event inputs plus pattern/playhead outputs of the step editor.
// Latency: n/a (wiring only).
// Backpressure: none; the master drives levels, the slave drives registered results.
interface step_editor_if;
  import sequencer_pkg::*;

  logic      button_pressed;
  step_idx_t button_index;
  logic      run;
  pattern_t  beats;
  logic      edit_valid;
  step_idx_t edit_step;
  step_idx_t play_step;
  step_val_t play_value;
  logic      step_tick;

  // Stimulus side: button scanner and transport control.
  modport master (
    output button_pressed, button_index, run,
    input  beats, edit_valid, edit_step, play_step, play_value, step_tick
  );

  // Editor side.
  modport slave (
    input  button_pressed, button_index, run,
    output beats, edit_valid, edit_step, play_step, play_value, step_tick
  );

endinterface

// File: rtl/step_editor_tempo_counter.sv
// tempo_counter: free-running step timer that advances the playhead every STEP_CYCLES cycles.
// Latency: play_step and step_tick update on the edge that samples the terminal count.
// Backpressure: run=0 freezes the counter and playhead and masks step_tick.
module tempo_counter
  import sequencer_pkg::*;
#(
  parameter int STEP_CYCLES = 1500000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      run,
  output logic      step_tick,
  output step_idx_t play_step
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam step_idx_t        STEP_LAST = IDX_W'(STEPS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  step_idx_t        step_q, step_d;
  logic             tick_q, tick_d;

  // Next-state: count while running, wrap and advance the playhead on terminal count.
  always_comb begin
    cnt_d  = cnt_q;
    step_d = step_q;
    tick_d = 1'b0;
    if (run) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d  = '0;
        step_d = (step_q == STEP_LAST) ? '0 : step_q + 1'b1;
        tick_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Tempo state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      step_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      step_q <= step_d;
      tick_q <= tick_d;
    end
  end

  // A stopped transport never reports a tick, even on the cycle run drops.
  assign step_tick = tick_q & run;
  assign play_step = step_q;

endmodule

// File: rtl/step_editor.sv
// step_editor: qualifies debounced button presses into step-value edits and runs the playhead.
// Latency: edit commits STABLE_CYCLES cycles after the first sampled press; beats/edit_valid one cycle later.
// Backpressure: none; inputs sampled every cycle. STEP_EDITOR_LONG_PRESS_CLEAR_EN adds long-press clear.
module step_editor
  import sequencer_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int STEP_CYCLES   = 1500000,
  parameter int HOLD_CYCLES   = 6000000
) (
  input  logic         clk,
  input  logic         rst,
  step_editor_if.slave bus
);

  localparam int STB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

  press_state_t     state_q, state_d;
  step_idx_t        cand_q, cand_d;
  logic [STB_W-1:0] stab_q, stab_d;
  pattern_t         beats_q, beats_d;
  logic             edit_valid_q, edit_valid_d;
  step_idx_t        edit_step_q, edit_step_d;
  logic             commit;
  logic             clear;
  logic             idx_match;
  step_idx_t        play_step;
  logic             step_tick;

  assign idx_match = (bus.button_index == cand_q);

  // Press FSM state register; reset always lands in IDLE regardless of the button level.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Press FSM next state: arm on press, hold after a stable run, release returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.button_pressed) begin
          state_d = ARM;
        end
      end
      ARM: begin
        if (!bus.button_pressed) begin
          state_d = IDLE;
        end else if (idx_match && (stab_q == STB_LAST)) begin
          state_d = HELD;
        end
      end
      HELD: begin
        if (!bus.button_pressed) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Press FSM outputs: candidate latch, stability counter and the commit strobe.
  always_comb begin
    cand_d = cand_q;
    stab_d = stab_q;
    commit = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.button_pressed) begin
          cand_d = bus.button_index;
          stab_d = '0;
        end
      end
      ARM: begin
        if (bus.button_pressed) begin
          if (!idx_match) begin
            // A different key restarts qualification from scratch.
            cand_d = bus.button_index;
            stab_d = '0;
          end else if (stab_q == STB_LAST) begin
            commit = 1'b1;
          end else begin
            stab_d = stab_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

`ifdef STEP_EDITOR_LONG_PRESS_CLEAR_EN
  localparam int HLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HLD_W-1:0] HLD_LAST = HLD_W'(HOLD_CYCLES - 1);

  logic [HLD_W-1:0] hold_q, hold_d;
  logic             fired_q, fired_d;

  // Hold timer: restarted by each commit, fires the clear once per hold.
  always_comb begin
    hold_d  = hold_q;
    fired_d = fired_q;
    clear   = 1'b0;
    if (commit) begin
      hold_d  = '0;
      fired_d = 1'b0;
    end else if ((state_q == HELD) && bus.button_pressed && !fired_q) begin
      if (hold_q == HLD_LAST) begin
        clear   = 1'b1;
        fired_d = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  // Hold timer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
    end
  end
`else
  // HELD has no timed action in this build; the hold threshold has no effect.
  assign clear = (HOLD_CYCLES < 0);
`endif

  // Pattern update: increment on commit (7 wraps to 0), zero on long-press clear.
  always_comb begin
    beats_d      = beats_q;
    edit_valid_d = 1'b0;
    edit_step_d  = edit_step_q;
    if (commit) begin
      beats_d[step_base(cand_q) +: VAL_W] = get_step(beats_q, cand_q) + 1'b1;
      edit_valid_d = 1'b1;
      edit_step_d  = cand_q;
    end else if (clear) begin
      beats_d[step_base(cand_q) +: VAL_W] = '0;
      edit_valid_d = 1'b1;
      edit_step_d  = cand_q;
    end
  end

  // Candidate, qualification counter, pattern and edit-report registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q       <= '0;
      stab_q       <= '0;
      beats_q      <= '0;
      edit_valid_q <= 1'b0;
      edit_step_q  <= '0;
    end else begin
      cand_q       <= cand_d;
      stab_q       <= stab_d;
      beats_q      <= beats_d;
      edit_valid_q <= edit_valid_d;
      edit_step_q  <= edit_step_d;
    end
  end

  tempo_counter #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_tempo (
    .clk       (clk),
    .rst       (rst),
    .run       (bus.run),
    .step_tick (step_tick),
    .play_step (play_step)
  );

  assign bus.beats      = beats_q;
  assign bus.edit_valid = edit_valid_q;
  assign bus.edit_step  = edit_step_q;
  assign bus.play_step  = play_step;
  assign bus.step_tick  = step_tick;
  // Read straight from the pattern register, so a same-edge edit shows immediately after that edge.
  assign bus.play_value = get_step(beats_q, play_step);

endmodule

// File: tb/tb_step_editor.sv
// tb_step_editor: randomized and directed checks of step_editor against a press/tempo reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_step_editor;
  import sequencer_pkg::*;

  localparam int STABLE = 4;
  localparam int STEPC  = 8;
  localparam int HOLD   = 20;
`ifdef STEP_EDITOR_LONG_PRESS_CLEAR_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  step_editor_if bus ();

  step_editor #(
    .STABLE_CYCLES (STABLE),
    .STEP_CYCLES   (STEPC),
    .HOLD_CYCLES   (HOLD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Reference model state: per-step values, press qualification, transport edges.
  int m_val [STEPS];
  int m_es = 0;
  int m_run_edges = 0;
  bit m_tick_q = 1'b0;
  int m_cand = 0;
  int m_samples = 0;
  bit m_held = 1'b0;
  int m_held_n = 0;
  bit m_fired = 1'b0;
  int m_pulses = 0;
  int d_pulses = 0;

  // Model: a press commits once it has been seen STABLE+1 consecutive cycles with one index.
  always @(posedge clk) begin
    if (rst) begin
      foreach (m_val[i]) m_val[i] = 0;
      m_es = 0; m_run_edges = 0; m_tick_q = 1'b0; m_cand = 0;
      m_samples = 0; m_held = 1'b0; m_held_n = 0; m_fired = 1'b0;
    end else begin
      if (bus.run) begin
        m_run_edges++;
        m_tick_q = ((m_run_edges % STEPC) == 0);
      end else begin
        m_tick_q = 1'b0;
      end
      if (!bus.button_pressed) begin
        m_held = 1'b0;
        m_samples = 0;
      end else if (m_held) begin
        m_held_n++;
        if (LP_EN && !m_fired && m_held_n == HOLD) begin
          m_val[m_cand] = 0; m_es = m_cand; m_fired = 1'b1; m_pulses++;
        end
      end else if (m_samples == 0 || int'(bus.button_index) != m_cand) begin
        m_cand = int'(bus.button_index);
        m_samples = 1;
      end else begin
        m_samples++;
        if (m_samples == STABLE + 1) begin
          m_val[m_cand] = (m_val[m_cand] + 1) % 8;
          m_es = m_cand; m_pulses++;
          m_held = 1'b1; m_held_n = 0; m_fired = 1'b0;
        end
      end
    end
  end

  // Observed edit pulses, counted just after each edge.
  always @(posedge clk) begin
    #1;
    if (bus.edit_valid === 1'b1) d_pulses++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  function automatic pattern_t model_pattern();
    pattern_t p = '0;
    for (int i = 0; i < STEPS; i++) p = p | (pattern_t'(m_val[i]) << (VAL_W * i));
    return p;
  endfunction

  function automatic int model_play_step();
    return (m_run_edges / STEPC) % STEPS;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; bus.button_pressed = 1'b0; bus.button_index = '0; bus.run = 1'b0;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.button_pressed = 1'b0; bus.button_index = '0; bus.run = 1'b0;
    idle(3);
    checks++; if (bus.beats !== '0) begin errors++; $display("FAIL reset_beats: got %0h want 0", bus.beats); end
    checks++; if (bus.edit_valid !== 1'b0) begin errors++; $display("FAIL reset_edit_valid: got %b want 0", bus.edit_valid); end
    checks++; if (bus.edit_step !== '0) begin errors++; $display("FAIL reset_edit_step: got %0d want 0", bus.edit_step); end
    checks++; if (bus.play_step !== '0) begin errors++; $display("FAIL reset_play_step: got %0d want 0", bus.play_step); end
    checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL reset_step_tick: got %b want 0", bus.step_tick); end
    rst = 1'b0;
  endtask

  task automatic test_single_press();
    int p0 = d_pulses;
    pattern_t exp_p = pattern_t'(1) << 15;
    bus.button_index = 4'd5; bus.button_pressed = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++; if (bus.edit_valid !== (c == 5)) begin errors++; $display("FAIL single_edit_valid: cycle %0d got %b want %b", c, bus.edit_valid, (c == 5)); end
      if (c == 5) begin
        checks++; if (bus.edit_step !== 4'd5) begin errors++; $display("FAIL single_edit_step: got %0d want 5", bus.edit_step); end
        checks++; if (bus.beats !== exp_p) begin errors++; $display("FAIL single_beats_edge: got %0h want %0h", bus.beats, exp_p); end
      end
    end
    bus.button_pressed = 1'b0;
    idle(3);
    checks++; if (d_pulses - p0 != 1) begin errors++; $display("FAIL single_pulses: got %0d want 1", d_pulses - p0); end
    checks++; if (bus.beats !== exp_p) begin errors++; $display("FAIL single_beats: got %0h want %0h", bus.beats, exp_p); end
  endtask

  task automatic test_wrap();
    logic [2:0] v;
    for (int k = 0; k < 8; k++) begin
      bus.button_index = 4'd3; bus.button_pressed = 1'b1;
      idle(6);
      bus.button_pressed = 1'b0;
      idle(2);
      v = bus.beats[11:9];
      checks++; if (v !== 3'((k + 1) % 8)) begin errors++; $display("FAIL wrap_step3: press %0d got %0d want %0d", k, v, (k + 1) % 8); end
    end
    checks++; if (bus.beats !== model_pattern()) begin errors++; $display("FAIL wrap_model: got %0h want %0h", bus.beats, model_pattern()); end
  endtask

  task automatic test_glitch();
    pattern_t snap = bus.beats;
    int p0 = d_pulses;
    bus.button_index = 4'($urandom_range(0, 15)); bus.button_pressed = 1'b1;
    idle(2);
    bus.button_pressed = 1'b0;
    idle(3);
    checks++; if (d_pulses != p0) begin errors++; $display("FAIL glitch_pulses: got %0d want %0d", d_pulses, p0); end
    checks++; if (bus.beats !== snap) begin errors++; $display("FAIL glitch_beats: got %0h want %0h", bus.beats, snap); end
    bus.button_index = 4'd2; bus.button_pressed = 1'b1;
    idle(2);
    bus.button_index = 4'd9;
    idle(8);
    bus.button_pressed = 1'b0;
    idle(2);
    checks++; if (bus.beats[8:6] !== snap[8:6]) begin errors++; $display("FAIL switch_step2: got %0d want %0d", bus.beats[8:6], snap[8:6]); end
    checks++; if (bus.beats[29:27] !== snap[29:27] + 3'd1) begin errors++; $display("FAIL switch_step9: got %0d want %0d", bus.beats[29:27], snap[29:27] + 3'd1); end
    checks++; if (d_pulses != p0 + 1) begin errors++; $display("FAIL switch_pulses: got %0d want %0d", d_pulses, p0 + 1); end
  endtask

  task automatic test_random();
    int len;
    for (int it = 0; it < 40; it++) begin
      bus.run = 1'($urandom_range(0, 1));
      bus.button_index = 4'($urandom_range(0, 15));
      bus.button_pressed = 1'b1;
      len = $urandom_range(1, 9);
      for (int j = 0; j < len; j++) begin
        if ($urandom_range(0, 7) == 0) bus.button_index = 4'($urandom_range(0, 15));
        @(negedge clk);
      end
      bus.button_pressed = 1'b0;
      idle($urandom_range(1, 3));
      checks++; if (bus.beats !== model_pattern()) begin errors++; $display("FAIL rand_beats: iter %0d got %0h want %0h", it, bus.beats, model_pattern()); end
      checks++; if (d_pulses != m_pulses) begin errors++; $display("FAIL rand_pulses: iter %0d got %0d want %0d", it, d_pulses, m_pulses); end
      checks++; if (int'(bus.edit_step) != m_es) begin errors++; $display("FAIL rand_edit_step: iter %0d got %0d want %0d", it, bus.edit_step, m_es); end
      checks++; if (int'(bus.play_step) != model_play_step()) begin errors++; $display("FAIL rand_play_step: iter %0d got %0d want %0d", it, bus.play_step, model_play_step()); end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_tempo();
    int exp_ps = 0;
    do_reset();
    bus.run = 1'b1;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      exp_ps = (c / STEPC) % STEPS;
      checks++; if (int'(bus.play_step) != exp_ps) begin errors++; $display("FAIL tempo_play_step: cycle %0d got %0d want %0d", c, bus.play_step, exp_ps); end
      checks++; if (bus.step_tick !== ((c % STEPC) == 0)) begin errors++; $display("FAIL tempo_tick: cycle %0d got %b want %b", c, bus.step_tick, ((c % STEPC) == 0)); end
    end
    bus.run = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checks++; if (int'(bus.play_step) != exp_ps) begin errors++; $display("FAIL frozen_play_step: got %0d want %0d", bus.play_step, exp_ps); end
      checks++; if (bus.step_tick !== 1'b0) begin errors++; $display("FAIL frozen_tick: got %b want 0", bus.step_tick); end
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.run = 1'b1;
    idle(27);
    bus.button_index = 4'd4; bus.button_pressed = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      checks++; if (int'(bus.play_step) != ((c == 5) ? 4 : 3)) begin errors++; $display("FAIL simul_play_step: cycle %0d got %0d want %0d", c, bus.play_step, (c == 5) ? 4 : 3); end
      checks++; if (bus.edit_valid !== (c == 5)) begin errors++; $display("FAIL simul_edit_valid: cycle %0d got %b want %b", c, bus.edit_valid, (c == 5)); end
    end
    checks++; if (bus.step_tick !== 1'b1) begin errors++; $display("FAIL simul_tick: got %b want 1", bus.step_tick); end
    checks++; if (bus.edit_step !== 4'd4) begin errors++; $display("FAIL simul_edit_step: got %0d want 4", bus.edit_step); end
    checks++; if (bus.play_value !== 3'd1) begin errors++; $display("FAIL simul_play_value: got %0d want 1", bus.play_value); end
    @(negedge clk);
    checks++; if (int'(bus.play_value) != m_val[4]) begin errors++; $display("FAIL simul_play_value_next: got %0d want %0d", bus.play_value, m_val[4]); end
    bus.button_pressed = 1'b0; bus.run = 1'b0;
    idle(2);
  endtask

  task automatic test_long_press();
    int p0;
    do_reset();
    p0 = d_pulses;
    bus.button_index = 4'd7; bus.button_pressed = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      checks++; if (bus.edit_valid !== ((c == 5) || (LP_EN && c == 25))) begin errors++; $display("FAIL long_edit_valid: cycle %0d got %b want %b", c, bus.edit_valid, ((c == 5) || (LP_EN && c == 25))); end
    end
    bus.button_pressed = 1'b0;
    idle(3);
    checks++; if (d_pulses - p0 != (LP_EN ? 2 : 1)) begin errors++; $display("FAIL long_pulses: got %0d want %0d", d_pulses - p0, LP_EN ? 2 : 1); end
    checks++; if (bus.beats[23:21] !== (LP_EN ? 3'd0 : 3'd1)) begin errors++; $display("FAIL long_step7: got %0d want %0d", bus.beats[23:21], LP_EN ? 0 : 1); end
    checks++; if (bus.beats !== model_pattern()) begin errors++; $display("FAIL long_model: got %0h want %0h", bus.beats, model_pattern()); end
  endtask

  task automatic test_reset_mid_hold();
    int p0;
    do_reset();
    bus.button_index = 4'd6; bus.button_pressed = 1'b1;
    idle(10);
    rst = 1'b1;
    idle(3);
    checks++; if (bus.beats !== '0) begin errors++; $display("FAIL midrst_beats: got %0h want 0", bus.beats); end
    checks++; if (bus.edit_valid !== 1'b0) begin errors++; $display("FAIL midrst_edit_valid: got %b want 0", bus.edit_valid); end
    p0 = d_pulses;
    rst = 1'b0; bus.button_pressed = 1'b0;
    idle(40);
    checks++; if (d_pulses != p0) begin errors++; $display("FAIL midrst_pulses: got %0d want %0d", d_pulses, p0); end
    checks++; if (bus.beats !== '0) begin errors++; $display("FAIL midrst_beats_after: got %0h want 0", bus.beats); end
    // Reset while still pressed: qualification restarts from IDLE once reset drops.
    rst = 1'b1; bus.button_pressed = 1'b1;
    idle(2);
    rst = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (bus.edit_valid !== (c == 5)) begin errors++; $display("FAIL rst_pressed_edit_valid: cycle %0d got %b want %b", c, bus.edit_valid, (c == 5)); end
    end
    bus.button_pressed = 1'b0;
    idle(2);
    checks++; if (bus.beats !== model_pattern()) begin errors++; $display("FAIL rst_pressed_model: got %0h want %0h", bus.beats, model_pattern()); end
  endtask

  initial begin
    bus.button_index = '0; bus.button_pressed = 1'b0; bus.run = 1'b0;
    test_reset();
    test_single_press();
    test_wrap();
    test_glitch();
    test_random();
    test_tempo();
    test_simultaneous();
    test_long_press();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
